// File: rtl/uart_wb_pkg.sv
// Shared constants for the UART slave: register offsets, STATUS/CTRL bit indices, FSM states.
package uart_wb_pkg;

  // Register select values, taken from adr[3:2]
  localparam logic [1:0] RegData    = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegCtrl    = 2'd2;
  localparam logic [1:0] RegDivisor = 2'd3;

  // STATUS bit indices
  localparam int unsigned BitRxNe     = 0;
  localparam int unsigned BitTxFull   = 1;
  localparam int unsigned BitTxIdle   = 2;
  localparam int unsigned BitOverrun  = 3;
  localparam int unsigned BitFrameErr = 4;

  // CTRL bit indices
  localparam int unsigned CtrlRxIe = 0;
  localparam int unsigned CtrlTxIe = 1;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  // RxBreak waits for the line to return high after a framing error
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with read-ahead output; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_wb.sv
// Memory-mapped 8N1 UART slave: bus register file, TX/RX FIFOs, inline TX and RX FSMs.
module uart_wb
  import uart_wb_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 217,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [3:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq,
  input  logic        rxd,
  output logic        txd
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic        armed_q, ack_q, irq_q, ovr_q, fe_q;
  logic [31:0] dat_q, rd_data, status;
  logic [1:0]  ctrl_q, reg_sel;
  logic [15:0] div_q, div_new;
  logic        access, ovr_set, fe_set, ovr_clr, fe_clr;

  logic          tx_push, tx_pop, tx_full, tx_empty, tx_idle;
  logic [7:0]    tx_rdata;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_rdata;
  logic [CW-1:0] rx_count;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        txd_q, txd_d;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;

  logic unused;
  assign unused = ^{dat_i[31:16], adr_i[1:0], sel_i[3:2], tx_count, rx_count};

  assign dat_o   = dat_q;
  assign ack_o   = ack_q;
  assign irq     = irq_q;
  assign txd     = txd_q;
  assign reg_sel = adr_i[3:2];
  // One access per strobe: armed_q drops on access and returns after stb_i is seen low
  assign access  = stb_i & armed_q;
  assign tx_idle = tx_empty & (tx_state_q == TxIdle);
  assign tx_push = access & we_i & (reg_sel == RegData) & sel_i[0];
  assign rx_pop  = access & ~we_i & (reg_sel == RegData);
  assign ovr_clr = access & we_i & (reg_sel == RegStatus) & sel_i[0] & dat_i[BitOverrun];
  assign fe_clr  = access & we_i & (reg_sel == RegStatus) & sel_i[0] & dat_i[BitFrameErr];
  assign div_new = {sel_i[1] ? dat_i[15:8] : div_q[15:8], sel_i[0] ? dat_i[7:0] : div_q[7:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_i   (rst_i),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (dat_i[7:0]),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (rx_sh_q),
    .rdata_o (rx_rdata),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  // Read-data mux for the addressed register
  always_comb begin
    status              = '0;
    status[BitRxNe]     = ~rx_empty;
    status[BitTxFull]   = tx_full;
    status[BitTxIdle]   = tx_idle;
    status[BitOverrun]  = ovr_q;
    status[BitFrameErr] = fe_q;
    rd_data             = '0;
    unique case (reg_sel)
      RegData:    rd_data = rx_empty ? 32'h0 : {24'h0, rx_rdata};
      RegStatus:  rd_data = status;
      RegCtrl:    rd_data = {30'h0, ctrl_q};
      RegDivisor: rd_data = {16'h0, div_q};
    endcase
  end

  // Bus handshake, register writes, sticky flags and interrupt
  always_ff @(posedge clk) begin
    if (rst_i) begin
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ctrl_q  <= '0;
      div_q   <= 16'(DEFAULT_DIV);
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ack_q <= access;
      if (access)      armed_q <= 1'b0;
      else if (!stb_i) armed_q <= 1'b1;
      if (access && !we_i) dat_q <= rd_data;
      if (access && we_i && reg_sel == RegCtrl && sel_i[0]) ctrl_q <= dat_i[1:0];
      if (access && we_i && reg_sel == RegDivisor && div_new >= 16'd3) div_q <= div_new;
      // A set in the same cycle as a clear wins
      ovr_q <= ovr_set | (ovr_q & ~ovr_clr);
      fe_q  <= fe_set | (fe_q & ~fe_clr);
      irq_q <= (ctrl_q[CtrlRxIe] & ~rx_empty) | (ctrl_q[CtrlTxIe] & tx_idle);
    end
  end

  // TX next state; the bit counter reloads from div_q at each boundary
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_pop     = 1'b0;
    if (tx_cnt_q != 16'd0) tx_cnt_d = tx_cnt_q - 16'd1;
    case (tx_state_q)
      TxIdle: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_rdata;
          tx_cnt_d   = div_q;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = div_q;
          tx_bit_d   = 3'd0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_q;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
        end
      end
      TxStop: begin
        if (tx_cnt_q == 16'd0) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_rdata;
            tx_cnt_d   = div_q;
            tx_state_d = TxStart;
          end else begin
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    case (tx_state_d)
      TxStart: txd_d = 1'b0;
      TxData:  txd_d = tx_sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
    end
  end

  // RX next state; sampling at mid-bit after a half-period start qualification
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_bit_d   = rx_bit_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    fe_set     = 1'b0;
    if (rx_cnt_q != 16'd0) rx_cnt_d = rx_cnt_q - 16'd1;
    case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = {1'b0, div_q[15:1]};
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_cnt_q == 16'd0) begin
          if (!rx_s2_q) begin
            rx_cnt_d   = div_q;
            rx_bit_d   = 3'd0;
            rx_state_d = RxData;
          end else begin
            rx_state_d = RxIdle;
          end
        end
      end
      RxData: begin
        if (rx_cnt_q == 16'd0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = div_q;
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_s2_q) begin
            if (rx_full) ovr_set = 1'b1;
            else         rx_push = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            fe_set     = 1'b1;
            rx_state_d = RxBreak;
          end
        end
      end
      RxBreak: begin
        if (rx_s2_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // RX synchroniser and state register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

endmodule

// File: tb/tb_uart_wb.sv
// Directed bench for uart_wb: register access, TX waveform, RX path, handshake, overrun, reset.
module tb_uart_wb;

  logic        clk = 1'b0;
  logic        rst_i, we_i, stb_i, ack_o, irq, txd, rxd, rxd_drv, loop;
  logic [3:0]  adr_i, sel_i;
  logic [31:0] dat_i, dat_o;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  assign rxd = loop ? txd : rxd_drv;

  uart_wb #(.DEFAULT_DIV(217), .FIFO_DEPTH(16)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .we_i  (we_i),
    .stb_i (stb_i),
    .sel_i (sel_i),
    .dat_o (dat_o),
    .ack_o (ack_o),
    .irq   (irq),
    .rxd   (rxd),
    .txd   (txd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [3:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rd);
    @(negedge clk);
    adr_i = a; we_i = w; dat_i = d; sel_i = 4'hF; stb_i = 1'b1;
    @(negedge clk);
    check("ack", ack_o, 1);
    rd = dat_o;
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] v;
    bus(a, 1'b1, d, v);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(a, 1'b0, 32'h0, v);
    check(tag, v, exp);
  endtask

  // Drive one 8N1 frame at 8 clocks per bit (DIVISOR = 7)
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (8) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (8) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_txd_low(output int n);
    n = 0;
    while (txd && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (txd) check("txd_start_timeout", txd, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, acks;
    logic [31:0] d0;
    logic [7:0]  pat;
    rst_i = 1'b1; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; sel_i = '0;
    rxd_drv = 1'b1; loop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_txd", txd, 1);
    check("rst_irq", irq, 0);
    rst_i = 1'b0;

    rd_chk("status_reset", 4'h4, 32'h4);
    rd_chk("div_reset", 4'hC, 32'd217);
    wr(4'hC, 32'd7);
    rd_chk("div_7", 4'hC, 32'd7);
    wr(4'hC, 32'd2);
    rd_chk("div_below3", 4'hC, 32'd7);

    // TX waveform for 0x55
    pat = 8'h55;
    wr(4'h0, 32'h55);
    wait_txd_low(n);
    check("tx_latency", 32'(n <= 2), 1);
    repeat (3) @(negedge clk);
    check("tx_start", txd, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(negedge clk);
      check("tx_bit", txd, 32'(pat[i]));
    end
    repeat (8) @(negedge clk);
    check("tx_stop", txd, 1);
    rd_chk("status_busy", 4'h4, 32'h0);
    repeat (8) @(negedge clk);
    rd_chk("status_idle", 4'h4, 32'h4);

    // TX-idle interrupt
    wr(4'h8, 32'h2);
    repeat (2) @(negedge clk);
    check("irq_txidle", irq, 1);
    wr(4'h8, 32'h0);
    repeat (2) @(negedge clk);
    check("irq_off", irq, 0);

    // Strobe held three cycles on a DATA read
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rd_chk("status_rx2", 4'h4, 32'h5);
    @(negedge clk);
    adr_i = 4'h0; we_i = 1'b0; sel_i = 4'hF; stb_i = 1'b1;
    acks = 0; d0 = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (ack_o) acks++;
      if (k == 1) d0 = dat_o;
      if (k == 2 || k == 3) check("hold_dat", dat_o, 32'h11);
      if (k == 3) stb_i = 1'b0;
    end
    check("hold_acks", acks, 1);
    check("hold_first", d0, 32'h11);
    rd_chk("hold_second", 4'h0, 32'h22);
    rd_chk("status_drained", 4'h4, 32'h4);
    rd_chk("data_empty", 4'h0, 32'h0);

    // Loopback with RX interrupt
    loop = 1'b1;
    wr(4'h8, 32'h1);
    rd_chk("ctrl_rb", 4'h8, 32'h1);
    wr(4'h0, 32'hA3);
    check("irq_pre", irq, 0);
    n = 0;
    while (!irq && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("irq_rx", irq, 1);
    rd_chk("lb_data", 4'h0, 32'hA3);
    @(negedge clk);
    check("irq_fall", irq, 0);
    repeat (10) @(negedge clk);
    loop = 1'b0;
    wr(4'h8, 32'h0);

    // Overrun, framing error and write-1-clear
    for (int i = 0; i < 17; i++) send_frame(8'h30 + 8'(i), 1'b1);
    rd_chk("status_ovr", 4'h4, 32'h0D);
    send_frame(8'h00, 1'b0);
    rd_chk("status_fe", 4'h4, 32'h1D);
    wr(4'h4, 32'h18);
    rd_chk("status_clr", 4'h4, 32'h05);
    for (int i = 0; i < 16; i++) rd_chk("rx_fifo", 4'h0, 32'h30 + 32'(i));
    rd_chk("status_empty", 4'h4, 32'h4);

    // Reset in the middle of a TX frame with bytes queued
    wr(4'h8, 32'h3);
    wr(4'h0, 32'h00);
    wr(4'h0, 32'h00);
    wr(4'h0, 32'h00);
    wait_txd_low(n);
    repeat (12) @(negedge clk);
    check("pre_rst_txd", txd, 0);
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_mid_txd", txd, 1);
    check("rst_mid_ack", ack_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    rd_chk("rst_status", 4'h4, 32'h4);
    rd_chk("rst_div", 4'hC, 32'd217);
    rd_chk("rst_ctrl", 4'h8, 32'h0);
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (!txd) n++;
    end
    check("no_tx_after_rst", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
